mem_bank_b_loader: RTL

Upstream feeder for the matrix-B memory-bank address generator. Accepts full-width bus beats of matrix B over a valid/ready handshake and splits each beat into BURST slices of ARRAY_WIDTH elements, one slice per cycle. Each slice is written to the B bank, and its write strobe drives the address generator's `valid_i`. Tracks the total slice count for an n×p matrix and signals completion.

---
 rtl/mm_pkg.sv | 29 ++
 rtl/mem_bank_b_loader.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-B bank loader and address generator.
// Keeps BURST / SLICE_W derivation and the loader FSM encoding in one place.
package mm_pkg;

    // Number of array-wide slices carried by one bus beat.
    function automatic int calc_burst(
        input int bus_width_bytes,
        input int data_width_bytes,
        input int array_width
    );
        return bus_width_bytes / data_width_bytes / array_width;
    endfunction

    // Bit width of one array-wide slice.
    function automatic int calc_slice_w(
        input int array_width,
        input int data_width_bytes
    );
        return array_width * data_width_bytes * 8;
    endfunction

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SLICE  = 2'd2,
        FINISH = 2'd3
    } ld_state_e;

endpackage

// File: rtl/mem_bank_b_loader.sv
// Matrix-B bank loader: splits bus beats into array-wide slices, one per
// cycle, and counts slices for an n x p load, pulsing done_o at the end.
import mm_pkg::*;

module mem_bank_b_loader #(
    parameter int ARRAY_WIDTH      = 4,
    parameter int BUS_WIDTH_BYTES  = 32,
    parameter int DATA_WIDTH_BYTES = 1
) (
    input  logic                                         clk,
    input  logic                                         reset_n,
    input  logic                                         start_i,
    input  logic [15:0]                                  n,
    input  logic [15:0]                                  p,
    input  logic                                         in_valid_i,
    input  logic [BUS_WIDTH_BYTES*8-1:0]                 in_data_i,
    output logic                                         in_ready_o,
    output logic                                         wr_valid_o,
    output logic [ARRAY_WIDTH*DATA_WIDTH_BYTES*8-1:0]    wr_data_o,
    output logic                                         busy_o,
    output logic                                         done_o
);

    localparam int BURST   = calc_burst(BUS_WIDTH_BYTES, DATA_WIDTH_BYTES,
                                        ARRAY_WIDTH);
    localparam int SLICE_W = calc_slice_w(ARRAY_WIDTH, DATA_WIDTH_BYTES);
    localparam int BUS_W   = BUS_WIDTH_BYTES * 8;
    localparam int K_W     = $clog2(BURST);

    localparam logic [K_W-1:0] K_LAST = K_W'(BURST - 1);

    ld_state_e         state_q, state_d;
    logic [K_W-1:0]    k_q, k_d;
    logic [31:0]       remaining_q, remaining_d;
    logic [BUS_W-1:0]  hold_q, hold_d;

    logic [31:0]       prod;
    logic [31:0]       s_total;
    logic              rem_bits;
    logic [SLICE_W-1:0] cur_slice;

    // Slice total for the requested matrix: ceil(n*p / ARRAY_WIDTH).
    always_comb begin
        prod     = 32'(n) * 32'(p);
        rem_bits = (prod % 32'(ARRAY_WIDTH)) != 32'd0;
        s_total  = (prod / 32'(ARRAY_WIDTH)) + {31'd0, rem_bits};
    end

    assign cur_slice = hold_q[int'(k_q)*SLICE_W +: SLICE_W];

    // State, slice index, slice counter and holding register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            k_q         <= '0;
            remaining_q <= '0;
            hold_q      <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            remaining_q <= remaining_d;
            hold_q      <= hold_d;
        end
    end

    // Next-state and output decode; start_i overrides everything else.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        remaining_d = remaining_q;
        hold_d      = hold_q;
        in_ready_o  = 1'b0;
        wr_valid_o  = 1'b0;
        wr_data_o   = '0;
        done_o      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    remaining_d = s_total;
                    k_d         = '0;
                    state_d     = (s_total == 32'd0) ? FINISH : LOAD;
                end
            end

            LOAD: begin
                in_ready_o = !start_i;
                if (start_i) begin
                    remaining_d = s_total;
                    k_d         = '0;
                    state_d     = (s_total == 32'd0) ? FINISH : LOAD;
                end else if (in_valid_i) begin
                    hold_d  = in_data_i;
                    k_d     = '0;
                    state_d = SLICE;
                end
            end

            SLICE: begin
                wr_valid_o = 1'b1;
                wr_data_o  = cur_slice;
                if (start_i) begin
                    remaining_d = s_total;
                    k_d         = '0;
                    state_d     = (s_total == 32'd0) ? FINISH : LOAD;
                end else begin
                    remaining_d = remaining_q - 32'd1;
                    k_d         = k_q + 1'b1;
                    if (remaining_q == 32'd1) begin
                        // Final slice; rest of this beat is dropped.
                        state_d = FINISH;
                    end else if (k_q == K_LAST) begin
                        in_ready_o = 1'b1;
                        if (in_valid_i) begin
                            hold_d  = in_data_i;
                            k_d     = '0;
                            state_d = SLICE;
                        end else begin
                            state_d = LOAD;
                        end
                    end
                end
            end

            FINISH: begin
                done_o = 1'b1;
                if (start_i) begin
                    remaining_d = s_total;
                    k_d         = '0;
                    state_d     = (s_total == 32'd0) ? FINISH : LOAD;
                end else begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_o = (state_q != IDLE);

endmodule
